noc_link_pipe: RTL and testbench

Pipelined, VC-aware inter-router link for the NoC mesh. It inserts `LINK_STAGES` register slices between two routers and keeps on/off flow control lossless across the added round-trip latency. A per-VC skid buffer at the receiving end absorbs in-flight flits. It replaces the zero-latency router-to-router link wherever long mesh wires need retiming.

---
 rtl/noc_link_pipe_pkg.sv | 14 +
 rtl/noc_link_pipe_fifo.sv | 52 +++++
 rtl/noc_link_pipe.sv | 151 +++++++++++++++
 tb/tb_noc_link_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pipe_pkg.sv
// Shared NoC parameters: flit format, VC count and link limits.
package noc_params;

    localparam int unsigned VC_NUM          = 2;
    localparam int unsigned VC_ID_W         = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned LINK_STAGES_MAX = 4;

    typedef struct packed {
        logic [VC_ID_W-1:0] vc_id;
        logic [DATA_W-1:0]  payload;
    } flit_t;

endpackage

// File: rtl/noc_link_pipe_fifo.sv
// Single-VC circular skid FIFO; caller must not push when full unless popping.
module link_vc_fifo
    import noc_params::*;
#(
    parameter  int unsigned DEPTH = 6,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  flit_t         push_data,
    input  logic          pop,
    output flit_t         head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    flit_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/noc_link_pipe.sv
// Pipelined VC-aware router link with per-VC skid buffering and round-robin output.
// Optional sticky overflow flags (err_o) are built when NOC_LINK_ERR_EN is defined.
module noc_link_pipe
    import noc_params::*;
#(
    parameter int unsigned LINK_STAGES = 2,
    parameter int unsigned SKID_DEPTH  = 2 * LINK_STAGES + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  flit_t             up_data_i,
    input  logic              up_is_valid_i,
    output logic [VC_NUM-1:0] up_is_on_off_o,
    output logic [VC_NUM-1:0] up_is_allocatable_o,
    output flit_t             dn_data_o,
    output logic              dn_is_valid_o,
    input  logic [VC_NUM-1:0] dn_is_on_off_i,
    input  logic [VC_NUM-1:0] dn_is_allocatable_i
`ifdef NOC_LINK_ERR_EN
    ,
    output logic [VC_NUM-1:0] err_o
`endif
);

    localparam int unsigned CW       = $clog2(SKID_DEPTH + 1);
    localparam int unsigned ON_LIMIT = SKID_DEPTH - 2 * LINK_STAGES;

    if (LINK_STAGES < 1 || LINK_STAGES > LINK_STAGES_MAX ||
        SKID_DEPTH < 2 * LINK_STAGES + 1) begin : g_bad_param
        $error("noc_link_pipe: illegal LINK_STAGES / SKID_DEPTH");
    end

    logic              fwd_valid [LINK_STAGES];
    flit_t             fwd_data  [LINK_STAGES];
    logic [VC_NUM-1:0] bwd_on    [LINK_STAGES];
    logic [VC_NUM-1:0] bwd_alloc [LINK_STAGES];

    logic              in_valid;
    flit_t             in_flit;
    logic [VC_NUM-1:0] push_here;
    logic [VC_NUM-1:0] eligible;
    logic [VC_NUM-1:0] granted;
    logic [VC_NUM-1:0] bypass;
    logic [VC_NUM-1:0] fifo_push;
    logic [VC_NUM-1:0] fifo_pop;
    logic [VC_NUM-1:0] full;
    logic [VC_NUM-1:0] empty;
    logic [VC_NUM-1:0] on_local;
    logic [VC_NUM-1:0] alloc_local;
    flit_t             head  [VC_NUM];
    logic [CW-1:0]     count [VC_NUM];

    logic [VC_ID_W-1:0] rr_ptr;
    logic [VC_ID_W-1:0] grant_vc;
    logic [VC_ID_W-1:0] cand;
    logic               grant_valid;
    flit_t              grant_flit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LINK_STAGES; i++) begin
                fwd_valid[i] <= 1'b0;
                fwd_data[i]  <= '0;
                bwd_on[i]    <= '0;
                bwd_alloc[i] <= '0;
            end
        end else begin
            fwd_valid[0] <= up_is_valid_i;
            fwd_data[0]  <= up_data_i;
            bwd_on[0]    <= on_local;
            bwd_alloc[0] <= alloc_local;
            for (int unsigned i = 1; i < LINK_STAGES; i++) begin
                fwd_valid[i] <= fwd_valid[i-1];
                fwd_data[i]  <= fwd_data[i-1];
                bwd_on[i]    <= bwd_on[i-1];
                bwd_alloc[i] <= bwd_alloc[i-1];
            end
        end
    end

    assign in_valid            = fwd_valid[LINK_STAGES-1];
    assign in_flit             = fwd_data[LINK_STAGES-1];
    assign up_is_on_off_o      = bwd_on[LINK_STAGES-1];
    assign up_is_allocatable_o = bwd_alloc[LINK_STAGES-1];

    // A flit arriving at an empty FIFO is eligible in its arrival cycle and,
    // if granted, goes straight to the output without being stored.
    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign push_here[v]   = in_valid && (in_flit.vc_id == VC_ID_W'(v));
        assign eligible[v]    = (!empty[v] || push_here[v]) && dn_is_on_off_i[v];
        assign granted[v]     = grant_valid && (grant_vc == VC_ID_W'(v));
        assign bypass[v]      = empty[v] && push_here[v] && granted[v];
        assign fifo_push[v]   = push_here[v] && !bypass[v] && (!full[v] || granted[v]);
        assign fifo_pop[v]    = granted[v] && !empty[v];
        assign on_local[v]    = (count[v] < CW'(ON_LIMIT));
        assign alloc_local[v] = dn_is_allocatable_i[v] && empty[v];

        link_vc_fifo #(
            .DEPTH(SKID_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (fifo_push[v]),
            .push_data(in_flit),
            .pop      (fifo_pop[v]),
            .head     (head[v]),
            .count    (count[v]),
            .full     (full[v]),
            .empty    (empty[v])
        );
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_vc    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < VC_NUM; k++) begin
            cand = VC_ID_W'((32'(rr_ptr) + k) % VC_NUM);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_vc    = cand;
            end
        end
        grant_flit = empty[grant_vc] ? in_flit : head[grant_vc];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dn_data_o     <= '0;
            dn_is_valid_o <= 1'b0;
            rr_ptr        <= '0;
        end else begin
            dn_is_valid_o <= grant_valid;
            if (grant_valid) begin
                dn_data_o <= grant_flit;
                rr_ptr    <= (32'(grant_vc) == VC_NUM - 1) ? '0 : grant_vc + 1'b1;
            end
        end
    end

`ifdef NOC_LINK_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o <= '0;
        end else begin
            err_o <= err_o | (push_here & full & ~granted);
        end
    end
`endif

endmodule

// File: tb/tb_noc_link_pipe.sv
// Directed self-checking bench for noc_link_pipe (LINK_STAGES = 2, SKID_DEPTH = 6).
module tb_noc_link_pipe;
    import noc_params::*;

    logic        clk = 1'b0;
    logic        rst;
    flit_t       up_data;
    logic        up_valid;
    logic [1:0]  up_on;
    logic [1:0]  up_alloc;
    flit_t       dn_data;
    logic        dn_valid;
    logic [1:0]  dn_on;
    logic [1:0]  dn_alloc;
`ifdef NOC_LINK_ERR_EN
    logic [1:0]  err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    noc_link_pipe #(
        .LINK_STAGES(2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .up_data_i          (up_data),
        .up_is_valid_i      (up_valid),
        .up_is_on_off_o     (up_on),
        .up_is_allocatable_o(up_alloc),
        .dn_data_o          (dn_data),
        .dn_is_valid_o      (dn_valid),
        .dn_is_on_off_i     (dn_on),
        .dn_is_allocatable_i(dn_alloc)
`ifdef NOC_LINK_ERR_EN
        ,
        .err_o              (err)
`endif
    );

    typedef struct packed {
        logic        v;
        logic        vc;
        logic [15:0] pl;
        logic [1:0]  on;
        logic [1:0]  al;
        logic        e_v;
        logic [16:0] e_data;
        logic [1:0]  e_on;
        logic [1:0]  e_al;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic vc, input logic [15:0] pl);
        up_valid      = v;
        up_data.vc_id = vc;
        up_data.payload = pl;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int bad;

        rst      = 1'b0;
        dn_on    = 2'b11;
        dn_alloc = 2'b11;
        drive(1'b0, 1'b0, 16'h0);

        tick();
        chk("rst_dn_valid", 32'(dn_valid), 0);
        chk("rst_dn_data",  32'(dn_data),  0);
        chk("rst_up_on",    32'(up_on),    0);
        chk("rst_up_alloc", 32'(up_alloc), 0);
`ifdef NOC_LINK_ERR_EN
        chk("rst_err", 32'(err), 0);
`endif
        rst = 1'b1;
        tick();
        chk("rel1_up_on", 32'(up_on), 0);
        tick();
        chk("rel2_up_on",    32'(up_on),    32'h3);
        chk("rel2_up_alloc", 32'(up_alloc), 32'h3);

        // Streaming with receiver on: latency 3, bypass keeps the FIFOs empty.
        tbl[0] = '{1'b1, 1'b0, 16'hA001, 2'b11, 2'b11, 1'b0, 17'h00000, 2'b11, 2'b11};
        tbl[1] = '{1'b1, 1'b1, 16'hB002, 2'b11, 2'b11, 1'b0, 17'h00000, 2'b11, 2'b11};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 2'b11, 2'b10, 1'b1, 17'h0A001, 2'b11, 2'b11};
        tbl[3] = '{1'b1, 1'b1, 16'hC003, 2'b11, 2'b10, 1'b1, 17'h1B002, 2'b11, 2'b10};
        tbl[4] = '{1'b1, 1'b0, 16'hD004, 2'b11, 2'b11, 1'b0, 17'h1B002, 2'b11, 2'b10};
        tbl[5] = '{1'b1, 1'b0, 16'hE005, 2'b11, 2'b11, 1'b1, 17'h1C003, 2'b11, 2'b11};
        tbl[6] = '{1'b0, 1'b0, 16'h0000, 2'b11, 2'b11, 1'b1, 17'h0D004, 2'b11, 2'b11};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 2'b11, 2'b11, 1'b1, 17'h0E005, 2'b11, 2'b11};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 2'b11, 2'b11, 1'b0, 17'h0E005, 2'b11, 2'b11};

        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].v, tbl[k].vc, tbl[k].pl);
            dn_on    = tbl[k].on;
            dn_alloc = tbl[k].al;
            tick();
            chk($sformatf("tbl%0d_dn_valid", k), 32'(dn_valid), 32'(tbl[k].e_v));
            chk($sformatf("tbl%0d_dn_data", k),  32'(dn_data),  32'(tbl[k].e_data));
            chk($sformatf("tbl%0d_up_on", k),    32'(up_on),    32'(tbl[k].e_on));
            chk($sformatf("tbl%0d_up_alloc", k), 32'(up_alloc), 32'(tbl[k].e_al));
        end

        // Flow control: VC1 receiver off, sender obeys up_on[1].
        dn_on = 2'b01;
        sent  = 0;
        bad   = 0;
        for (int i = 0; i < 20; i++) begin
            if (dn_valid) bad++;
            if (up_on[1]) begin
                drive(1'b1, 1'b1, 16'h0100 + 16'(sent));
                sent++;
            end else begin
                drive(1'b0, 1'b0, 16'h0);
            end
            tick();
        end
        chk("fc_sent", 32'(sent), 6);
        chk("fc_no_output_while_off", 32'(bad), 0);
        chk("fc_up_on_low", 32'(up_on), 32'h1);
`ifdef NOC_LINK_ERR_EN
        chk("fc_err", 32'(err), 0);
`endif
        dn_on = 2'b11;
        tick();
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("fc_drain%0d_valid", j), 32'(dn_valid), 1);
            chk($sformatf("fc_drain%0d_data", j),  32'(dn_data), 32'h10100 + 32'(j));
            tick();
        end
        chk("fc_drain_end", 32'(dn_valid), 0);

        // Round-robin: both VCs buffered, then both receivers on.
        dn_on = 2'b00;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'(i % 2), 16'h0200 + 16'(i));
            tick();
        end
        drive(1'b0, 1'b0, 16'h0);
        repeat (4) tick();
        chk("rr_idle_valid", 32'(dn_valid), 0);
        dn_on = 2'b11;
        tick();
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("rr%0d_valid", j), 32'(dn_valid), 1);
            chk($sformatf("rr%0d_data", j),  32'(dn_data),
                (32'(j % 2) << 16) | (32'h0200 + 32'(j)));
            tick();
        end
        chk("rr_end", 32'(dn_valid), 0);

        // Allocatable held low while FIFO[0] is occupied.
        dn_on    = 2'b00;
        dn_alloc = 2'b11;
        do_reset();
        tick();
        tick();
        chk("al_init", 32'(up_alloc), 32'h3);
        drive(1'b1, 1'b0, 16'h5A5A);
        tick();
        drive(1'b0, 1'b0, 16'h0);
        repeat (7) tick();
        chk("al_held_low", 32'(up_alloc), 32'h2);
        dn_on = 2'b01;
        tick();
        chk("al_pop_valid", 32'(dn_valid), 1);
        chk("al_pop_data",  32'(dn_data), 32'h05A5A);
        chk("al_p1", 32'(up_alloc), 32'h2);
        tick();
        chk("al_p2", 32'(up_alloc), 32'h2);
        tick();
        chk("al_p3", 32'(up_alloc), 32'h3);

        // Reset mid-transfer: flits in stages and buffered are discarded.
        dn_on = 2'b00;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 16'h0400 + 16'(i));
            tick();
        end
        drive(1'b1, 1'b0, 16'h0406);
        rst = 1'b0;
        tick();
        chk("mid_rst_dn_valid", 32'(dn_valid), 0);
        chk("mid_rst_dn_data",  32'(dn_data),  0);
        chk("mid_rst_up_on",    32'(up_on),    0);
        chk("mid_rst_up_alloc", 32'(up_alloc), 0);
        drive(1'b0, 1'b0, 16'h0);
        dn_on = 2'b11;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rel1_up_on", 32'(up_on), 0);
        tick();
        chk("mid_rel2_up_on", 32'(up_on), 32'h3);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (dn_valid) bad++;
            tick();
        end
        chk("mid_no_replay", 32'(bad), 0);

        // Overflow: seven flits forced into VC1 while its receiver is off.
        dn_on = 2'b00;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 16'h0300 + 16'(i));
            tick();
        end
        drive(1'b0, 1'b0, 16'h0);
        tick();
`ifdef NOC_LINK_ERR_EN
        chk("ovf_err_before", 32'(err), 0);
`endif
        tick();
`ifdef NOC_LINK_ERR_EN
        chk("ovf_err_set", 32'(err), 32'h2);
`endif
        dn_on = 2'b11;
        tick();
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("ovf_drain%0d_valid", j), 32'(dn_valid), 1);
            chk($sformatf("ovf_drain%0d_data", j),  32'(dn_data), 32'h10300 + 32'(j));
            tick();
        end
        chk("ovf_dropped", 32'(dn_valid), 0);
`ifdef NOC_LINK_ERR_EN
        chk("ovf_err_sticky", 32'(err), 32'h2);
        do_reset();
        tick();
        chk("ovf_err_cleared", 32'(err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
